// File: rtl/iterative_shift_ctrl.sv
// iterative_shift_ctrl
// Multi-cycle shift unit that walks the log-stage shifters (2**(SHAMT_W-1) ... 1)
// one stage per clock over a held operand. Intended as a small shift path
// next to the ALU. Results are returned with a one-cycle data_resultRDY pulse.
//
// Handshake: a request is taken on a rising edge where ready=1 and
// ctrl_start=1; operand, op and shamt are captured on that edge only. ready is
// high in IDLE and DONE, so a new request can be taken in the same cycle the
// previous result is presented (no idle bubble). ctrl_start while busy=1 is
// ignored. data_result is valid only while data_resultRDY=1 and otherwise holds.
module iterative_shift_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = 5,
  parameter int SKIP_ZERO = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [1:0]         ctrl_op,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] ctrl_shamt,
  output logic               ready,
  output logic               busy,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               data_exception
);

  localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Current FSM state; kept as a plain named signal so checkers can bind to it.
  state_t             state;

  logic [WIDTH-1:0]   work;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [SHAMT_W-1:0] remaining;
  logic [IDX_W-1:0]   stage;

  logic [IDX_W-1:0]   step_idx;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] next_rem;
  logic               step_en;
  logic               last_step;
  logic [WIDTH-1:0]   shifted;
  logic               zero_latency;

  // One shifter stage. SRA relies on work[WIDTH-1] still equalling the
  // captured operand's sign bit, which holds because every SRA step preserves it.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0]   v,
                                                input logic [1:0]         op,
                                                input logic [SHAMT_W-1:0] amt);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = v << amt;
      OP_SRA:  r = $unsigned($signed(v) >>> amt);
      OP_SRL:  r = v >> amt;
      default: r = v;
    endcase
    return r;
  endfunction

  // Select which stage this edge handles and compute the stepped work value.
  always_comb begin
    step_idx = '0;
    step_en  = 1'b0;
    if (SKIP_ZERO != 0) begin
      // highest set bit of remaining: ascending scan, last hit wins
      for (int i = 0; i < SHAMT_W; i++) begin
        if (remaining[i]) step_idx = IDX_W'(i);
      end
      step_en = |remaining;
    end else begin
      step_idx = stage;
      step_en  = shamt_q[stage];
    end
    step_amt  = SHAMT_W'(1) << step_idx;
    next_rem  = remaining & ~step_amt;
    last_step = (SKIP_ZERO != 0) ? (next_rem == '0) : (stage == '0);
    shifted   = (step_en && (op_q != OP_ILL)) ? shift_by(work, op_q, step_amt) : work;
  end

  assign zero_latency = (SKIP_ZERO != 0) && (ctrl_shamt == '0);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      work           <= '0;
      op_q           <= OP_SLL;
      shamt_q        <= '0;
      remaining      <= '0;
      stage          <= '0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      busy           <= 1'b0;
      ready          <= 1'b1;
    end else begin
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (ctrl_start) begin
            work      <= data_operand;
            op_q      <= ctrl_op;
            shamt_q   <= ctrl_shamt;
            remaining <= ctrl_shamt;
            stage     <= IDX_W'(SHAMT_W - 1);
            if (zero_latency) begin
              // nothing to shift: present the operand on the very next cycle
              state          <= S_DONE;
              data_result    <= data_operand;
              data_resultRDY <= 1'b1;
              data_exception <= (ctrl_op == OP_ILL);
              busy           <= 1'b0;
              ready          <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
              ready <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          work      <= shifted;
          remaining <= next_rem;
          stage     <= stage - 1'b1;
          if (last_step) begin
            state          <= S_DONE;
            data_result    <= shifted;
            data_resultRDY <= 1'b1;
            data_exception <= (op_q == OP_ILL);
            busy           <= 1'b0;
            ready          <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shift_ctrl.sv
// tb_iterative_shift_ctrl
// Two instances: index 0 runs every stage (SKIP_ZERO=0), index 1 skips zero
// stages (SKIP_ZERO=1). A latency/result model tracks each instance and is
// compared against the outputs on every falling edge; directed operations
// carry hand-computed results and latencies.
module tb_iterative_shift_ctrl;

  localparam int W = 32;
  localparam int S = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         start   [2];
  logic [1:0]   op      [2];
  logic [W-1:0] operand [2];
  logic [S-1:0] shamt   [2];
  logic         ready   [2];
  logic         busy    [2];
  logic         rdy     [2];
  logic         exc     [2];
  logic [W-1:0] result  [2];

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  iterative_shift_ctrl #(.WIDTH(W), .SHAMT_W(S), .SKIP_ZERO(0)) dut0 (
    .clock(clock), .reset(reset), .ctrl_start(start[0]), .ctrl_op(op[0]),
    .data_operand(operand[0]), .ctrl_shamt(shamt[0]), .ready(ready[0]),
    .busy(busy[0]), .data_result(result[0]), .data_resultRDY(rdy[0]),
    .data_exception(exc[0]));

  iterative_shift_ctrl #(.WIDTH(W), .SHAMT_W(S), .SKIP_ZERO(1)) dut1 (
    .clock(clock), .reset(reset), .ctrl_start(start[1]), .ctrl_op(op[1]),
    .data_operand(operand[1]), .ctrl_shamt(shamt[1]), .ready(ready[1]),
    .busy(busy[1]), .data_result(result[1]), .data_resultRDY(rdy[1]),
    .data_exception(exc[1]));

  task automatic chk(input string nm, input int d, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_cnt      [2];
  logic         m_rdy      [2];
  logic         m_exc      [2];
  logic [W-1:0] m_res      [2];
  logic [W-1:0] m_pend     [2];
  logic         m_pend_exc [2];

  function automatic logic [W-1:0] expect_fn(input logic [1:0] o, input logic [W-1:0] v,
                                             input logic [S-1:0] sh);
    case (o)
      2'b00:   return v << sh;
      2'b01:   return $unsigned($signed(v) >>> sh);
      2'b10:   return v >> sh;
      default: return v;
    endcase
  endfunction

  function automatic int latency(input int d, input logic [S-1:0] sh);
    return (d == 0) ? S : $countones(sh);
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_cnt[d] = 0; m_rdy[d] = 1'b0; m_exc[d] = 1'b0; m_res[d] = '0;
      end else begin
        m_rdy[d] = 1'b0;
        m_exc[d] = 1'b0;
        if (m_cnt[d] == 0) begin
          if (start[d]) begin
            m_pend[d]     = expect_fn(op[d], operand[d], shamt[d]);
            m_pend_exc[d] = (op[d] == 2'b11);
            m_cnt[d]      = latency(d, shamt[d]);
            if (m_cnt[d] == 0) begin
              m_rdy[d] = 1'b1; m_exc[d] = m_pend_exc[d]; m_res[d] = m_pend[d];
            end
          end
        end else begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_rdy[d] = 1'b1; m_exc[d] = m_pend_exc[d]; m_res[d] = m_pend[d];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("ready",  d, ready[d],  m_cnt[d] == 0);
        chk("busy",   d, busy[d],   m_cnt[d] != 0);
        chk("rdy",    d, rdy[d],    m_rdy[d]);
        chk("exc",    d, exc[d],    m_exc[d]);
        chk("result", d, result[d], m_res[d]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge where RDY is seen.
  task automatic run_op(input int d, input logic [1:0] o, input logic [W-1:0] v,
                        input logic [S-1:0] sh, input logic [W-1:0] exp_res,
                        input logic exp_exc, input int exp_lat);
    int lat;
    start[d] = 1'b1; op[d] = o; operand[d] = v; shamt[d] = sh;
    @(posedge clock);
    @(negedge clock);
    start[d] = 1'b0; operand[d] = ~v; shamt[d] = ~sh; op[d] = ~o;
    chk("accept_busy", d, busy[d], exp_lat != 0);
    lat = 0;
    while (!rdy[d] && lat < 40) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    chk("latency", d, lat, exp_lat);
    chk("lit_result", d, result[d], exp_res);
    chk("lit_exc", d, exc[d], exp_exc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  int pulses;
  logic [W-1:0] seen;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; op[d] = 2'b00; operand[d] = '0; shamt[d] = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_result", d, result[d], 32'h0);
      chk("rst_ready",  d, ready[d],  1'b1);
      chk("rst_busy",   d, busy[d],   1'b0);
      chk("rst_rdy",    d, rdy[d],    1'b0);
      chk("rst_exc",    d, exc[d],    1'b0);
    end
    chk_en = 1'b1;
    reset = 1'b0;
    idle(1);

    // full-latency instance
    run_op(0, 2'b01, 32'h8000_0000, 5'd8,  32'hFF80_0000, 1'b0, 5); idle(2);
    run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 5); idle(1);
    run_op(0, 2'b10, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 5); idle(1);
    run_op(0, 2'b00, 32'h0000_00A5, 5'd0,  32'h0000_00A5, 1'b0, 5); idle(1);
    run_op(0, 2'b01, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF, 1'b0, 5); idle(1);

    // zero-skipping instance
    run_op(1, 2'b00, 32'h1234_5678, 5'd0,     32'h1234_5678, 1'b0, 0); idle(2);
    run_op(1, 2'b10, 32'h8000_0000, 5'b10100, 32'h0000_0800, 1'b0, 2); idle(1);
    run_op(1, 2'b01, 32'h8000_0000, 5'd31,    32'hFFFF_FFFF, 1'b0, 5); idle(1);
    run_op(1, 2'b00, 32'h0000_0003, 5'd1,     32'h0000_0006, 1'b0, 1); idle(1);
    run_op(1, 2'b11, 32'hCAFE_F00D, 5'd0,     32'hCAFE_F00D, 1'b1, 0); idle(2);

    // start during SHIFT is ignored
    start[0] = 1'b1; op[0] = 2'b00; operand[0] = 32'h0000_000F; shamt[0] = 5'd4;
    @(posedge clock); @(negedge clock);
    start[0] = 1'b0; operand[0] = 32'h0;
    @(negedge clock);
    start[0] = 1'b1; op[0] = 2'b10; operand[0] = 32'hFFFF_FFFF; shamt[0] = 5'd1;
    @(negedge clock);
    start[0] = 1'b0;
    pulses = 0; seen = '0;
    repeat (12) begin
      @(negedge clock);
      if (rdy[0]) begin pulses++; seen = result[0]; end
    end
    chk("ignore_pulses", 0, pulses, 1);
    chk("ignore_result", 0, seen, 32'h0000_00F0);

    // reset two cycles into SHIFT aborts the operation
    start[0] = 1'b1; op[0] = 2'b00; operand[0] = 32'h0000_0001; shamt[0] = 5'd3;
    @(posedge clock); @(negedge clock);
    start[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_result", 0, result[0], 32'h0);
    chk("abort_ready",  0, ready[0],  1'b1);
    chk("abort_busy",   0, busy[0],   1'b0);
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (rdy[0]) pulses++;
    end
    chk("abort_pulses", 0, pulses, 0);
    run_op(0, 2'b00, 32'h0000_0001, 5'd3, 32'h0000_0008, 1'b0, 5); idle(1);

    // illegal op, then back-to-back start taken in DONE
    run_op(0, 2'b11, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1, 5);
    chk("b2b_ready", 0, ready[0], 1'b1);
    run_op(0, 2'b00, 32'h0000_0001, 5'd3, 32'h0000_0008, 1'b0, 5);
    run_op(0, 2'b10, 32'h0000_FF00, 5'd8, 32'h0000_00FF, 1'b0, 5);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
